// File: rtl/gamepad_pmod_multi_if.sv
// Pin and decoded-output bundle for the multi-pad Gamepad Pmod receiver.
// master drives the Pmod pins and observes the results; slave is the receiver.
interface gamepad_pmod_multi_if #(
    parameter int NUM_PADS = 2,
    parameter int PAD_BITS = 12
);
    logic                         pmod_data;
    logic                         pmod_clk;
    logic                         pmod_latch;
    logic [NUM_PADS*PAD_BITS-1:0] buttons;
    logic [NUM_PADS*PAD_BITS-1:0] pressed;
    logic [NUM_PADS*PAD_BITS-1:0] released;
    logic [NUM_PADS-1:0]          present;
    logic                         frame_valid;
    logic                         frame_err;
    logic                         link_ok;

    modport master (
        output pmod_data, pmod_clk, pmod_latch,
        input  buttons, pressed, released, present, frame_valid, frame_err, link_ok
    );

    modport slave (
        input  pmod_data, pmod_clk, pmod_latch,
        output buttons, pressed, released, present, frame_valid, frame_err, link_ok
    );
endinterface

// File: rtl/gamepad_pmod_multi.sv
// N-pad Gamepad Pmod receiver: sync pins, shift + length-check frames, decode, edge events, watchdog.
// Latency: latch pin high sampled at edge k -> outputs at edge k+3; no backpressure, outputs are levels/pulses.
module gamepad_pmod_multi #(
    parameter int NUM_PADS       = 2,
    parameter int PAD_BITS       = 12,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int TO_W           = 22
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gamepad_pmod_multi_if.slave   pad_if
);
    localparam int W  = NUM_PADS * PAD_BITS;
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0]   CNT_FULL = CW'(W);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(W + 1);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

    // Pin vectors are packed {latch, clk, data}
    logic [2:0]      sync0_q, sync1_q, prev_q;
    logic [W-1:0]    shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    raw_q, raw_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            commit_q, commit_d;
    logic            err_q, err_d;
    logic            link_q, link_d;
    logic            timeout;

    logic [W-1:0]        buttons_q, buttons_d, pressed_q, released_q;
    logic [NUM_PADS-1:0] present_q, present_d;
    logic                frame_valid_q, frame_err_q;

    logic clk_rise, latch_rise, data_s;
    assign clk_rise   = sync1_q[1] & ~prev_q[1];
    assign latch_rise = sync1_q[2] & ~prev_q[2];
    assign data_s     = sync1_q[0];

    // The length check and commit see the pre-shift state when clk and latch edges coincide
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        raw_d    = raw_q;
        wd_d     = wd_q;
        commit_d = 1'b0;
        err_d    = 1'b0;
        timeout  = 1'b0;
        if (clk_rise) begin
            shift_d = {shift_q[W-2:0], data_s};
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
        if (latch_rise) begin
            if (cnt_q == CNT_FULL) commit_d = 1'b1;
            else                   err_d    = 1'b1;
            cnt_d = clk_rise ? CW'(1) : '0;
        end
        if (commit_d) begin
            raw_d = shift_q;
            wd_d  = '0;
        end else if (wd_q == TO_MAX) begin
            raw_d   = '1;
            timeout = 1'b1;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_comb begin
        link_d = link_q;
        if (commit_q)     link_d = 1'b1;
        else if (timeout) link_d = 1'b0;
    end

    // An all-ones slice means nobody is pulling the line: pad absent
    always_comb begin
        present_d = '0;
        buttons_d = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            present_d[p] = (raw_q[p*PAD_BITS +: PAD_BITS] != {PAD_BITS{1'b1}});
            if (present_d[p]) buttons_d[p*PAD_BITS +: PAD_BITS] = raw_q[p*PAD_BITS +: PAD_BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0_q       <= '0;
            sync1_q       <= '0;
            prev_q        <= '0;
            shift_q       <= '1;
            cnt_q         <= '0;
            raw_q         <= '1;
            wd_q          <= '0;
            commit_q      <= 1'b0;
            err_q         <= 1'b0;
            link_q        <= 1'b0;
            buttons_q     <= '0;
            pressed_q     <= '0;
            released_q    <= '0;
            present_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            sync0_q       <= {pad_if.pmod_latch, pad_if.pmod_clk, pad_if.pmod_data};
            sync1_q       <= sync0_q;
            prev_q        <= sync1_q;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            raw_q         <= raw_d;
            wd_q          <= wd_d;
            commit_q      <= commit_d;
            err_q         <= err_d;
            link_q        <= link_d;
            buttons_q     <= buttons_d;
            pressed_q     <= buttons_d & ~buttons_q;
            released_q    <= ~buttons_d & buttons_q;
            present_q     <= present_d;
            frame_valid_q <= commit_q;
            frame_err_q   <= err_q;
        end
    end

    assign pad_if.buttons     = buttons_q;
    assign pad_if.pressed     = pressed_q;
    assign pad_if.released    = released_q;
    assign pad_if.present     = present_q;
    assign pad_if.frame_valid = frame_valid_q;
    assign pad_if.frame_err   = frame_err_q;
    assign pad_if.link_ok     = link_q;
endmodule

// File: tb/tb_gamepad_pmod_multi.sv
// Bench for gamepad_pmod_multi: two pads, short watchdog, scoreboard of committed frames.
module tb_gamepad_pmod_multi;
    localparam int NP = 2;
    localparam int PB = 12;
    localparam int W  = NP * PB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gamepad_pmod_multi_if #(.NUM_PADS(NP), .PAD_BITS(PB)) pif();

    gamepad_pmod_multi #(
        .NUM_PADS(NP), .PAD_BITS(PB), .TIMEOUT_CYCLES(1000), .TO_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pad_if(pif)
    );

    typedef struct {
        logic [W-1:0]  buttons;
        logic [W-1:0]  pressed;
        logic [W-1:0]  released;
        logic [NP-1:0] present;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] model_prev = '0;
    int errors = 0, checks = 0, fv_pulses = 0, err_pulses = 0;

    task automatic push_frame(input logic [W-1:0] f);
        exp_t e;
        e.buttons = '0;
        e.present = '0;
        for (int p = 0; p < NP; p++) begin
            e.present[p] = (f[p*PB +: PB] != {PB{1'b1}});
            if (e.present[p]) e.buttons[p*PB +: PB] = f[p*PB +: PB];
        end
        e.pressed  = e.buttons & ~model_prev;
        e.released = ~e.buttons & model_prev;
        model_prev = e.buttons;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every committed frame must match the oldest expected entry
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (pif.frame_err) err_pulses++;
            if (pif.frame_valid) begin
                fv_pulses++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: frame_valid with no expected frame, buttons=%h", pif.buttons);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if (pif.buttons !== e.buttons) begin
                        errors++;
                        $display("FAIL sb_buttons: got %h want %h", pif.buttons, e.buttons);
                    end
                    checks++;
                    if (pif.present !== e.present) begin
                        errors++;
                        $display("FAIL sb_present: got %b want %b", pif.present, e.present);
                    end
                    checks++;
                    if (pif.pressed !== e.pressed) begin
                        errors++;
                        $display("FAIL sb_pressed: got %h want %h", pif.pressed, e.pressed);
                    end
                    checks++;
                    if (pif.released !== e.released) begin
                        errors++;
                        $display("FAIL sb_released: got %h want %h", pif.released, e.released);
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        pif.pmod_data = b;
        pif.pmod_clk  = 1'b0;
        repeat (2) @(negedge clk);
        pif.pmod_clk = 1'b1;
        repeat (2) @(negedge clk);
        pif.pmod_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // Edge 0 is the first clk edge that samples latch high
    task automatic pulse_latch(output int fv_at, output int err_at, output int fv_cnt);
        fv_at = -1; err_at = -1; fv_cnt = 0;
        @(negedge clk);
        pif.pmod_latch = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (pif.frame_valid) begin
                if (fv_at < 0) fv_at = i;
                fv_cnt++;
            end
            if (pif.frame_err && err_at < 0) err_at = i;
            if (i == 2) pif.pmod_latch = 1'b0;
        end
    endtask

    task automatic test_reset();
        pif.pmod_data = 1'b0; pif.pmod_clk = 1'b0; pif.pmod_latch = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pif.buttons, pif.pressed, pif.released} !== '0) begin
            errors++;
            $display("FAIL reset_buses: got %h/%h/%h want 0", pif.buttons, pif.pressed, pif.released);
        end
        checks++;
        if ({pif.present, pif.frame_valid, pif.frame_err, pif.link_ok} !== '0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0", {pif.present, pif.frame_valid, pif.frame_err, pif.link_ok});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_first_frame();
        int fa, ea, fc;
        push_frame({12'hFFF, 12'h800});
        send_bits({8'h00, 12'hFFF, 12'h800}, W);
        pulse_latch(fa, ea, fc);
        checks++;
        if (fa !== 3) begin errors++; $display("FAIL first_latency: got %0d want 3", fa); end
        checks++;
        if (fc !== 1) begin errors++; $display("FAIL first_fv_width: got %0d want 1", fc); end
        checks++;
        if (pif.present !== 2'b01 || pif.buttons[11] !== 1'b1) begin
            errors++;
            $display("FAIL first_decode: present=%b buttons=%h want 01/bit11", pif.present, pif.buttons);
        end
        checks++;
        if (pif.pressed !== '0 || pif.link_ok !== 1'b1) begin
            errors++;
            $display("FAIL first_after: pressed=%h link_ok=%b want 0/1", pif.pressed, pif.link_ok);
        end
    endtask

    task automatic test_repeat_release();
        int fa, ea, fc;
        push_frame({12'hFFF, 12'h800});
        send_bits({8'h00, 12'hFFF, 12'h800}, W);
        pulse_latch(fa, ea, fc);
        checks++;
        if (fa !== 3) begin errors++; $display("FAIL repeat_latency: got %0d want 3", fa); end
        push_frame({12'hFFF, 12'h000});
        send_bits({8'h00, 12'hFFF, 12'h000}, W);
        pulse_latch(fa, ea, fc);
        checks++;
        if (pif.buttons !== '0 || pif.released !== '0 || pif.present !== 2'b01) begin
            errors++;
            $display("FAIL release_after: buttons=%h released=%h present=%b want 0/0/01",
                     pif.buttons, pif.released, pif.present);
        end
    endtask

    task automatic test_bad_length();
        int fa, ea, fc;
        int lens[2];
        logic [W-1:0] b0;
        logic [NP-1:0] p0;
        lens[0] = 23; lens[1] = 25;
        push_frame({12'h456, 12'h123});
        send_bits({8'h00, 12'h456, 12'h123}, W);
        pulse_latch(fa, ea, fc);
        b0 = pif.buttons; p0 = pif.present;
        for (int k = 0; k < 2; k++) begin
            send_bits(32'h00A5A5A5, lens[k]);
            pulse_latch(fa, ea, fc);
            checks++;
            if (ea !== 3 || fa !== -1) begin
                errors++;
                $display("FAIL badlen%0d_pulse: err_at=%0d fv_at=%0d want 3/-1", lens[k], ea, fa);
            end
            checks++;
            if (pif.buttons !== b0 || pif.present !== p0 || pif.link_ok !== 1'b1) begin
                errors++;
                $display("FAIL badlen%0d_hold: buttons=%h present=%b link=%b want %h/%b/1",
                         lens[k], pif.buttons, pif.present, pif.link_ok, b0, p0);
            end
        end
    endtask

    task automatic test_watchdog();
        int fa, ea, fc, n, drop_n, rel_cnt;
        logic [W-1:0] rel_val;
        push_frame({12'hFFF, 12'h801});
        send_bits({8'h00, 12'hFFF, 12'h801}, W);
        pulse_latch(fa, ea, fc);
        checks++;
        if (pif.link_ok !== 1'b1) begin errors++; $display("FAIL wd_link_up: got %b want 1", pif.link_ok); end
        n = 4; drop_n = -1; rel_cnt = 0; rel_val = '0;
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (pif.link_ok === 1'b0 && drop_n < 0) drop_n = n;
            if (pif.released !== '0) begin
                rel_cnt++;
                rel_val = pif.released;
            end
        end
        model_prev = '0;
        checks++;
        if (drop_n < 990 || drop_n > 1010) begin
            errors++;
            $display("FAIL wd_drop_time: link dropped %0d cycles after frame_valid, want ~1000", drop_n);
        end
        checks++;
        if (rel_cnt !== 1 || rel_val !== 24'h000801) begin
            errors++;
            $display("FAIL wd_released: cycles=%0d value=%h want 1/000801", rel_cnt, rel_val);
        end
        checks++;
        if (pif.buttons !== '0 || pif.present !== '0) begin
            errors++;
            $display("FAIL wd_cleared: buttons=%h present=%b want 0/00", pif.buttons, pif.present);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fa, ea, fc;
        push_frame({12'hFFF, 12'h800});
        send_bits({8'h00, 12'hFFF, 12'h800}, W);
        pulse_latch(fa, ea, fc);
        send_bits(32'h000002AA, 10);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({pif.buttons, pif.pressed, pif.released, pif.present,
             pif.frame_valid, pif.frame_err, pif.link_ok} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: buttons=%h present=%b link=%b want all 0",
                     pif.buttons, pif.present, pif.link_ok);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_prev = '0;
        repeat (3) @(negedge clk);
        push_frame({12'hFFF, 12'h010});
        send_bits({8'h00, 12'hFFF, 12'h010}, W);
        pulse_latch(fa, ea, fc);
        checks++;
        if (fa !== 3) begin errors++; $display("FAIL midreset_next: fv_at=%0d want 3", fa); end
    endtask

    task automatic test_back_to_back();
        int fa, ea, fc, e0, v0;
        logic [31:0] f1, f2;
        f1 = {8'h00, 12'h0A0, 12'h00F};
        f2 = {8'h00, 12'h0A0, 12'h0F0};
        e0 = err_pulses; v0 = fv_pulses;
        push_frame(f1[W-1:0]);
        push_frame(f2[W-1:0]);
        send_bits(f1, W);
        @(negedge clk);
        pif.pmod_data = f2[W-1];
        repeat (2) @(negedge clk);
        pif.pmod_clk = 1'b1;
        pif.pmod_latch = 1'b1;
        repeat (3) @(negedge clk);
        pif.pmod_clk = 1'b0;
        pif.pmod_latch = 1'b0;
        send_bits(f2, W - 1);
        pulse_latch(fa, ea, fc);
        checks++;
        if (fa !== 3 || ea !== -1) begin
            errors++;
            $display("FAIL b2b_second: fv_at=%0d err_at=%0d want 3/-1", fa, ea);
        end
        checks++;
        if (fv_pulses - v0 !== 2 || err_pulses !== e0) begin
            errors++;
            $display("FAIL b2b_counts: frames=%0d errs=%0d want 2/0", fv_pulses - v0, err_pulses - e0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_repeat_release();
        test_bad_length();
        test_watchdog();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected frames never committed", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
